// File: rtl/cfu_pkg.sv
// Shared defaults for the CFU interface modules and the reorder-slot state type.
package cfu_pkg;

  localparam int unsigned CFU_INTERFACE_ID_W_DEF = 16;
  localparam int unsigned CFU_FUNCTION_ID_W_DEF  = 16;
  localparam int unsigned CFU_REORDER_ID_W_DEF   = 8;
  localparam int unsigned CFU_REQ_RESP_ID_W_DEF  = 6;
  localparam int unsigned CFU_REQ_INPUTS_DEF     = 2;
  localparam int unsigned CFU_REQ_DATA_W_DEF     = 32;
  localparam int unsigned CFU_RESP_OUTPUTS_DEF   = 1;
  localparam int unsigned CFU_DEPTH_DEF          = 4;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_PENDING = 2'd1,
    SLOT_DONE    = 2'd2
  } slot_state_e;

endpackage

// File: rtl/cfu_reorder_table.sv
// Circular in-flight table: allocates slots in issue order, absorbs
// out-of-order responses by slot index, and presents the head slot for
// in-order retirement. Callers gate issue/resp_fire/retire with clock enable.
module cfu_reorder_table
  import cfu_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ID_W   = 6,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ERR_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue,
  input  logic              resp_fire,
  input  logic [ID_W-1:0]   resp_id,
  input  logic [DATA_W-1:0] resp_data,
  input  logic              resp_ok,
  input  logic [ERR_W-1:0]  resp_error_id,
  input  logic              retire,
  output logic [ID_W-1:0]   tail_id,
  output logic              not_full,
  output logic              head_done,
  output logic [DATA_W-1:0] head_data,
  output logic              head_ok,
  output logic [ERR_W-1:0]  head_error_id,
  output logic              protocol_error
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [ID_W:0]  DEPTH_ID  = (ID_W+1)'(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  slot_state_e       state     [DEPTH];
  logic [DATA_W-1:0] slot_data [DEPTH];
  logic              slot_ok   [DEPTH];
  logic [ERR_W-1:0]  slot_err  [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] resp_slot;
  logic             resp_hit;

  // Response lookup and head/tail views of the table.
  always_comb begin
    resp_slot = resp_id[PTR_W-1:0];
    // Range check first so an out-of-range id never aliases onto a live slot.
    resp_hit  = ({1'b0, resp_id} < DEPTH_ID) && (state[resp_slot] == SLOT_PENDING);
    tail_id   = '0;
    tail_id[PTR_W-1:0] = tail;
    not_full      = count < DEPTH_CNT;
    head_done     = state[head] == SLOT_DONE;
    head_data     = slot_data[head];
    head_ok       = slot_ok[head];
    head_error_id = slot_err[head];
  end

  // Slot states, pointers, occupancy and the sticky protocol error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) state[i] <= SLOT_FREE;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      protocol_error <= 1'b0;
    end else begin
      // Issue, response and retire always address distinct slots, so all
      // three updates may land in the same cycle.
      if (issue) begin
        state[tail] <= SLOT_PENDING;
        tail        <= tail + PTR_W'(1);
      end
      if (resp_fire) begin
        if (resp_hit) state[resp_slot] <= SLOT_DONE;
        else          protocol_error   <= 1'b1;
      end
      if (retire) begin
        state[head] <= SLOT_FREE;
        head        <= head + PTR_W'(1);
      end
      case ({issue, retire})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Response payload capture; payload is only meaningful while a slot is DONE.
  always_ff @(posedge clock) begin
    if (resp_fire && resp_hit) begin
      slot_data[resp_slot] <= resp_data;
      slot_ok[resp_slot]   <= resp_ok;
      slot_err[resp_slot]  <= resp_error_id;
    end
  end

endmodule

// File: rtl/cfu_initiator.sv
// Core-side CFU master: passes commands straight through as requests,
// tracks them in a reorder table and returns results in issue order.
module cfu_initiator
  import cfu_pkg::*;
#(
  parameter int unsigned CFU_INTERFACE_ID_W = CFU_INTERFACE_ID_W_DEF,
  parameter int unsigned CFU_FUNCTION_ID_W  = CFU_FUNCTION_ID_W_DEF,
  parameter int unsigned CFU_REORDER_ID_W   = CFU_REORDER_ID_W_DEF,
  parameter int unsigned CFU_REQ_RESP_ID_W  = CFU_REQ_RESP_ID_W_DEF,
  parameter int unsigned CFU_REQ_INPUTS     = CFU_REQ_INPUTS_DEF,
  parameter int unsigned CFU_REQ_DATA_W     = CFU_REQ_DATA_W_DEF,
  parameter int unsigned CFU_RESP_OUTPUTS   = CFU_RESP_OUTPUTS_DEF,
  parameter int unsigned CFU_RESP_DATA_W    = CFU_REQ_DATA_W,
  parameter int unsigned CFU_ERROR_ID_W     = CFU_RESP_DATA_W,
  parameter int unsigned DEPTH              = CFU_DEPTH_DEF
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       clock_en,
  output logic                                       cmd_ready,
  input  logic                                       cmd_valid,
  input  logic [CFU_INTERFACE_ID_W-1:0]              cmd_interface_id,
  input  logic [CFU_FUNCTION_ID_W-1:0]               cmd_function_id,
  input  logic [CFU_REORDER_ID_W-1:0]                cmd_reorder_id,
  input  logic [CFU_REQ_INPUTS*CFU_REQ_DATA_W-1:0]   cmd_data,
  input  logic                                       req_ready,
  output logic                                       req_valid,
  output logic [CFU_INTERFACE_ID_W-1:0]              req_interface_id,
  output logic [CFU_FUNCTION_ID_W-1:0]               req_function_id,
  output logic [CFU_REORDER_ID_W-1:0]                req_reorder_id,
  output logic [CFU_REQ_RESP_ID_W-1:0]               req_id,
  output logic [CFU_REQ_INPUTS*CFU_REQ_DATA_W-1:0]   req_data,
  output logic                                       resp_ready,
  input  logic                                       resp_valid,
  input  logic [CFU_REQ_RESP_ID_W-1:0]               resp_id,
  input  logic [CFU_RESP_OUTPUTS*CFU_RESP_DATA_W-1:0] resp_data,
  input  logic                                       resp_ok,
  input  logic [CFU_ERROR_ID_W-1:0]                  resp_error_id,
  input  logic                                       result_ready,
  output logic                                       result_valid,
  output logic [CFU_RESP_OUTPUTS*CFU_RESP_DATA_W-1:0] result_data,
  output logic                                       result_ok,
  output logic [CFU_ERROR_ID_W-1:0]                  result_error_id,
  output logic                                       protocol_error
);

  localparam int unsigned RESULT_W = CFU_RESP_OUTPUTS * CFU_RESP_DATA_W;

  logic active;
  logic not_full;
  logic issue;
  logic resp_fire;
  logic retire;
  logic head_done;

  // Handshake gating and command-to-request pass-through.
  always_comb begin
    active           = clock_en & ~reset;
    req_valid        = cmd_valid & not_full & active;
    cmd_ready        = req_ready & not_full & active;
    issue            = req_valid & req_ready;
    resp_ready       = active;
    resp_fire        = resp_valid & active;
    result_valid     = head_done & active;
    retire           = result_valid & result_ready;
    req_interface_id = cmd_interface_id;
    req_function_id  = cmd_function_id;
    req_reorder_id   = cmd_reorder_id;
    req_data         = cmd_data;
  end

  cfu_reorder_table #(
    .DEPTH  (DEPTH),
    .ID_W   (CFU_REQ_RESP_ID_W),
    .DATA_W (RESULT_W),
    .ERR_W  (CFU_ERROR_ID_W)
  ) u_table (
    .clock          (clock),
    .reset          (reset),
    .issue          (issue),
    .resp_fire      (resp_fire),
    .resp_id        (resp_id),
    .resp_data      (resp_data),
    .resp_ok        (resp_ok),
    .resp_error_id  (resp_error_id),
    .retire         (retire),
    .tail_id        (req_id),
    .not_full       (not_full),
    .head_done      (head_done),
    .head_data      (result_data),
    .head_ok        (result_ok),
    .head_error_id  (result_error_id),
    .protocol_error (protocol_error)
  );

endmodule

// File: tb/tb_cfu_initiator.sv
// Self-checking bench for cfu_initiator: directed scenarios plus a randomized
// run checked against an issue-ordered queue model of in-flight commands.
module tb_cfu_initiator;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDW   = 6;

  logic        clock = 1'b0;
  logic        reset;
  logic        clock_en;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [15:0] cmd_interface_id;
  logic [15:0] cmd_function_id;
  logic [7:0]  cmd_reorder_id;
  logic [63:0] cmd_data;
  logic        req_ready;
  logic        req_valid;
  logic [15:0] req_interface_id;
  logic [15:0] req_function_id;
  logic [7:0]  req_reorder_id;
  logic [5:0]  req_id;
  logic [63:0] req_data;
  logic        resp_ready;
  logic        resp_valid;
  logic [5:0]  resp_id;
  logic [31:0] resp_data;
  logic        resp_ok;
  logic [31:0] resp_error_id;
  logic        result_ready;
  logic        result_valid;
  logic [31:0] result_data;
  logic        result_ok;
  logic [31:0] result_error_id;
  logic        protocol_error;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    data;
    logic           ok;
    logic [31:0]    err;
    bit             done;
  } rec_t;

  typedef struct {
    int          due;
    logic [5:0]  id;
    logic [31:0] data;
  } pipe_t;

  always #5 clock = ~clock;

  cfu_initiator #(.DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .clock_en         (clock_en),
    .cmd_ready        (cmd_ready),
    .cmd_valid        (cmd_valid),
    .cmd_interface_id (cmd_interface_id),
    .cmd_function_id  (cmd_function_id),
    .cmd_reorder_id   (cmd_reorder_id),
    .cmd_data         (cmd_data),
    .req_ready        (req_ready),
    .req_valid        (req_valid),
    .req_interface_id (req_interface_id),
    .req_function_id  (req_function_id),
    .req_reorder_id   (req_reorder_id),
    .req_id           (req_id),
    .req_data         (req_data),
    .resp_ready       (resp_ready),
    .resp_valid       (resp_valid),
    .resp_id          (resp_id),
    .resp_data        (resp_data),
    .resp_ok          (resp_ok),
    .resp_error_id    (resp_error_id),
    .result_ready     (result_ready),
    .result_valid     (result_valid),
    .result_data      (result_data),
    .result_ok        (result_ok),
    .result_error_id  (result_error_id),
    .protocol_error   (protocol_error)
  );

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_idle();
    clock_en         = 1'b1;
    cmd_valid        = 1'b0;
    cmd_interface_id = '0;
    cmd_function_id  = '0;
    cmd_reorder_id   = '0;
    cmd_data         = '0;
    req_ready        = 1'b1;
    resp_valid       = 1'b0;
    resp_id          = '0;
    resp_data        = '0;
    resp_ok          = 1'b1;
    resp_error_id    = '0;
    result_ready     = 1'b1;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    cmd_valid = 1'b1;
    resp_valid = 1'b1;
    cycle();
    settle();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
    checks++; if (resp_ready !== 1'b0) begin errors++; $display("FAIL reset_resp_ready: got %b expected 0", resp_ready); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid: got %b expected 0", result_valid); end
    checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL reset_protocol_error: got %b expected 0", protocol_error); end
    reset = 1'b0;
    drive_idle();
    cycle();
    cmd_valid        = 1'b1;
    req_ready        = 1'b0;
    cmd_interface_id = 16'h1A2B;
    cmd_function_id  = 16'h3C4D;
    cmd_reorder_id   = 8'h5E;
    cmd_data         = 64'h0123_4567_89AB_CDEF;
    settle();
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL post_reset_req_valid: got %b expected 1", req_valid); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL stalled_cmd_ready: got %b expected 0", cmd_ready); end
    checks++; if (resp_ready !== 1'b1) begin errors++; $display("FAIL post_reset_resp_ready: got %b expected 1", resp_ready); end
    checks++; if (req_id !== 6'd0) begin errors++; $display("FAIL post_reset_req_id: got %0d expected 0", req_id); end
    checks++; if (req_interface_id !== 16'h1A2B || req_function_id !== 16'h3C4D || req_reorder_id !== 8'h5E)
      begin errors++; $display("FAIL passthrough_ids: got %h/%h/%h expected 1a2b/3c4d/5e", req_interface_id, req_function_id, req_reorder_id); end
    checks++; if (req_data !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL passthrough_data: got %h expected 0123456789abcdef", req_data); end
    cycle();
  endtask

  task automatic test_in_order();
    logic [31:0] exp_res [4];
    pipe_t       pipe [$];
    pipe_t       p;
    int          got;
    exp_res = '{32'd6, 32'd20, 32'd42, 32'd72};
    got = 0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      drive_idle();
      if (c < 4) begin
        cmd_valid = 1'b1;
        cmd_data  = {32'(2 * c + 3), 32'(2 * c + 2)};
      end
      if (pipe.size() > 0 && pipe[0].due == c) begin
        resp_valid = 1'b1;
        resp_id    = pipe[0].id;
        resp_data  = pipe[0].data;
      end
      settle();
      if (c < 4) begin
        checks++; if (req_valid !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL inorder_issue: got valid=%b ready=%b expected 1/1", req_valid, cmd_ready); end
        checks++; if (req_id !== 6'(c)) begin errors++; $display("FAIL inorder_req_id: got %0d expected %0d", req_id, c); end
        p.due  = c + 3;
        p.id   = req_id;
        p.data = req_data[31:0] * req_data[63:32];
        pipe.push_back(p);
      end
      if (result_valid) begin
        if (got < 4) begin
          checks++; if (result_data !== exp_res[got] || result_ok !== 1'b1)
            begin errors++; $display("FAIL inorder_result: got %0d ok=%b expected %0d ok=1", result_data, result_ok, exp_res[got]); end
        end
        got++;
      end
      if (resp_valid) void'(pipe.pop_front());
      cycle();
    end
    checks++; if (got != 4) begin errors++; $display("FAIL inorder_count: got %0d expected 4", got); end
  endtask

  task automatic test_out_of_order();
    logic [5:0]  ids [4];
    logic [31:0] dat [4];
    logic [31:0] seen [$];
    ids = '{6'd2, 6'd0, 6'd3, 6'd1};
    dat = '{32'hA2, 32'hA0, 32'hA3, 32'hA1};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive_idle();
      cmd_valid = 1'b1;
      settle();
      checks++; if (req_id !== 6'(c)) begin errors++; $display("FAIL ooo_req_id: got %0d expected %0d", req_id, c); end
      cycle();
    end
    for (int c = 0; c < 12; c++) begin
      drive_idle();
      if (c < 4) begin
        resp_valid = 1'b1;
        resp_id    = ids[c];
        resp_data  = dat[c];
      end
      settle();
      if (c < 2) begin
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL ooo_wait_head: got %b expected 0 at step %0d", result_valid, c); end
      end
      if (result_valid) seen.push_back(result_data);
      cycle();
    end
    checks++; if (seen.size() != 4) begin errors++; $display("FAIL ooo_count: got %0d expected 4", seen.size()); end
    for (int k = 0; k < 4 && k < seen.size(); k++) begin
      checks++; if (seen[k] !== 32'hA0 + 32'(k)) begin errors++; $display("FAIL ooo_order: got %h expected %h", seen[k], 32'hA0 + 32'(k)); end
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive_idle();
      cmd_valid = 1'b1;
      settle();
      cycle();
    end
    drive_idle();
    cmd_valid = 1'b1;
    settle();
    checks++; if (cmd_ready !== 1'b0 || req_valid !== 1'b0) begin errors++; $display("FAIL full_block: got ready=%b valid=%b expected 0/0", cmd_ready, req_valid); end
    cycle();
    drive_idle();
    cmd_valid  = 1'b1;
    resp_valid = 1'b1;
    resp_id    = 6'd0;
    resp_data  = 32'h1234;
    settle();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL full_resp_cycle: got req_valid=%b expected 0", req_valid); end
    cycle();
    drive_idle();
    cmd_valid = 1'b1;
    settle();
    checks++; if (result_valid !== 1'b1 || result_data !== 32'h1234) begin errors++; $display("FAIL full_head_result: got %b/%h expected 1/1234", result_valid, result_data); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL full_retire_cycle: got req_valid=%b expected 0", req_valid); end
    cycle();
    drive_idle();
    cmd_valid = 1'b1;
    settle();
    checks++; if (cmd_ready !== 1'b1 || req_valid !== 1'b1 || req_id !== 6'd0)
      begin errors++; $display("FAIL full_wrap: got ready=%b valid=%b id=%0d expected 1/1/0", cmd_ready, req_valid, req_id); end
    cycle();
    drive_idle();
    cmd_valid = 1'b1;
    settle();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_again: got %b expected 0", cmd_ready); end
    cycle();
  endtask

  task automatic test_error();
    do_reset();
    drive_idle();
    cmd_valid = 1'b1;
    settle();
    cycle();
    drive_idle();
    result_ready  = 1'b0;
    resp_valid    = 1'b1;
    resp_id       = 6'd0;
    resp_data     = 32'hDEAD;
    resp_ok       = 1'b0;
    resp_error_id = 32'h55;
    settle();
    cycle();
    drive_idle();
    result_ready = 1'b0;
    settle();
    checks++; if (result_valid !== 1'b1 || result_ok !== 1'b0 || result_error_id !== 32'h55)
      begin errors++; $display("FAIL error_status: got valid=%b ok=%b err=%h expected 1/0/55", result_valid, result_ok, result_error_id); end
    cycle();
  endtask

  task automatic test_bad_response();
    do_reset();
    drive_idle();
    result_ready = 1'b0;
    cmd_valid    = 1'b1;
    settle();
    cycle();
    drive_idle();
    result_ready = 1'b0;
    resp_valid   = 1'b1;
    resp_id      = 6'd1;
    resp_data    = 32'd77;
    settle();
    cycle();
    drive_idle();
    result_ready = 1'b0;
    settle();
    checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL bad_free_slot_flag: got %b expected 1", protocol_error); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL bad_no_result: got %b expected 0", result_valid); end
    checks++; if (req_id !== 6'd1) begin errors++; $display("FAIL bad_tail_held: got %0d expected 1", req_id); end
    resp_valid = 1'b1;
    resp_id    = 6'd0;
    resp_data  = 32'hBEEF;
    cycle();
    drive_idle();
    settle();
    checks++; if (result_valid !== 1'b1 || result_data !== 32'hBEEF) begin errors++; $display("FAIL bad_slot0_intact: got %b/%h expected 1/beef", result_valid, result_data); end
    cycle();
    drive_idle();
    settle();
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL bad_slot1_not_done: got %b expected 0", result_valid); end
    checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL bad_sticky: got %b expected 1", protocol_error); end
    do_reset();
    settle();
    checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL bad_reset_clears: got %b expected 0", protocol_error); end
    resp_valid = 1'b1;
    resp_id    = 6'd9;
    cycle();
    drive_idle();
    settle();
    checks++; if (protocol_error !== 1'b1 || result_valid !== 1'b0) begin errors++; $display("FAIL bad_out_of_range: got err=%b valid=%b expected 1/0", protocol_error, result_valid); end
    cycle();
  endtask

  task automatic test_clock_en();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      drive_idle();
      cmd_valid = 1'b1;
      settle();
      cycle();
    end
    drive_idle();
    result_ready = 1'b0;
    resp_valid   = 1'b1;
    resp_id      = 6'd0;
    resp_data    = 32'hC0;
    settle();
    cycle();
    for (int k = 0; k < 3; k++) begin
      drive_idle();
      clock_en     = 1'b0;
      cmd_valid    = 1'b1;
      resp_valid   = 1'b1;
      resp_id      = 6'd1;
      resp_data    = 32'hC1;
      result_ready = 1'b1;
      settle();
      checks++; if (req_valid !== 1'b0 || cmd_ready !== 1'b0 || resp_ready !== 1'b0 || result_valid !== 1'b0)
        begin errors++; $display("FAIL ce_handshakes: got %b%b%b%b expected 0000", req_valid, cmd_ready, resp_ready, result_valid); end
      cycle();
    end
    drive_idle();
    result_ready = 1'b0;
    settle();
    checks++; if (result_valid !== 1'b1 || result_data !== 32'hC0) begin errors++; $display("FAIL ce_head_held: got %b/%h expected 1/c0", result_valid, result_data); end
    checks++; if (req_id !== 6'd2 || protocol_error !== 1'b0) begin errors++; $display("FAIL ce_tail_held: got id=%0d err=%b expected 2/0", req_id, protocol_error); end
    result_ready = 1'b1;
    cycle();
    drive_idle();
    settle();
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL ce_resp_suppressed: got %b expected 0", result_valid); end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    settle();
    checks++; if (result_valid !== 1'b0 || req_id !== 6'd0) begin errors++; $display("FAIL midreset_state: got valid=%b id=%0d expected 0/0", result_valid, req_id); end
    resp_valid = 1'b1;
    resp_id    = 6'd1;
    cycle();
    drive_idle();
    settle();
    checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL midreset_stale_resp: got %b expected 1", protocol_error); end
    for (int c = 0; c < 5; c++) begin
      drive_idle();
      cmd_valid = 1'b1;
      settle();
      checks++; if (cmd_ready !== (c < 4)) begin errors++; $display("FAIL midreset_count: got ready=%b expected %b at issue %0d", cmd_ready, (c < 4), c); end
      cycle();
    end
  endtask

  task automatic test_random();
    rec_t q [$];
    rec_t r;
    int   cand [$];
    int   issued;
    int   pick;
    bit   room;
    bit   exp_issue;
    bit   exp_rv;
    issued = 0;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      drive_idle();
      clock_en         = ($urandom_range(9) != 0);
      cmd_valid        = ($urandom_range(3) != 0);
      cmd_data         = {$urandom, $urandom};
      cmd_interface_id = 16'($urandom);
      cmd_function_id  = 16'($urandom);
      cmd_reorder_id   = 8'($urandom);
      req_ready        = ($urandom_range(3) != 0);
      result_ready     = ($urandom_range(3) != 0);
      pick = -1;
      cand.delete();
      for (int i = 0; i < q.size(); i++) if (!q[i].done) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(1) == 1) pick = cand[$urandom_range(cand.size() - 1)];
      if (pick >= 0) begin
        resp_valid    = 1'b1;
        resp_id       = q[pick].id;
        resp_data     = q[pick].data;
        resp_ok       = q[pick].ok;
        resp_error_id = q[pick].err;
      end
      settle();
      room      = q.size() < DEPTH;
      exp_issue = cmd_valid && req_ready && clock_en && room;
      exp_rv    = clock_en && q.size() > 0 && q[0].done;
      checks++; if (req_valid !== (cmd_valid && clock_en && room)) begin errors++; $display("FAIL rnd_req_valid: got %b expected %b cycle %0d", req_valid, (cmd_valid && clock_en && room), c); end
      checks++; if (cmd_ready !== (req_ready && clock_en && room)) begin errors++; $display("FAIL rnd_cmd_ready: got %b expected %b cycle %0d", cmd_ready, (req_ready && clock_en && room), c); end
      checks++; if (resp_ready !== clock_en) begin errors++; $display("FAIL rnd_resp_ready: got %b expected %b cycle %0d", resp_ready, clock_en, c); end
      checks++; if (result_valid !== exp_rv) begin errors++; $display("FAIL rnd_result_valid: got %b expected %b cycle %0d", result_valid, exp_rv, c); end
      checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL rnd_protocol_error: got %b expected 0 cycle %0d", protocol_error, c); end
      if (exp_issue) begin
        checks++; if (req_id !== 6'(issued % DEPTH)) begin errors++; $display("FAIL rnd_req_id: got %0d expected %0d cycle %0d", req_id, issued % DEPTH, c); end
        checks++; if (req_data !== cmd_data || req_function_id !== cmd_function_id) begin errors++; $display("FAIL rnd_passthrough: got %h expected %h cycle %0d", req_data, cmd_data, c); end
      end
      if (exp_rv) begin
        checks++; if (result_data !== q[0].data || result_ok !== q[0].ok) begin errors++; $display("FAIL rnd_result: got %h ok=%b expected %h ok=%b cycle %0d", result_data, result_ok, q[0].data, q[0].ok, c); end
        if (!q[0].ok) begin
          checks++; if (result_error_id !== q[0].err) begin errors++; $display("FAIL rnd_error_id: got %h expected %h cycle %0d", result_error_id, q[0].err, c); end
        end
      end
      cycle();
      if (pick >= 0 && clock_en) q[pick].done = 1'b1;
      if (exp_rv && result_ready) void'(q.pop_front());
      if (exp_issue) begin
        r.id   = IDW'(issued % DEPTH);
        r.data = cmd_data[31:0] * cmd_data[63:32];
        r.ok   = ($urandom_range(3) != 0);
        r.err  = $urandom;
        r.done = 1'b0;
        q.push_back(r);
        issued++;
      end
    end
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_in_order();
    test_out_of_order();
    test_full();
    test_error();
    test_bad_response();
    test_clock_en();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
